// File: rtl/avalon_led_sequencer.sv
// Avalon-MM LED owner: LEDs driven either by software (SWDATA) or by a prescaled
// pattern sequencer (rotate, bounce, blink) with button pause/single-step control.
module avalon_led_sequencer #(
  parameter int LED_W     = 8,
  parameter int PRESC_W   = 24,
  parameter int PRESC_RST = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  input  logic [3:0]        buttons_n,
  input  logic [3:0]        dipsw,
  output logic [LED_W-1:0]  leds
);

  // Avalon handshake: fixed timing, no waitrequest. A write lands on the clock edge
  // where avs_write is sampled; a read is sampled likewise and avs_readdata holds the
  // selected register exactly one cycle later (readLatency=1) and keeps it until the next read.

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_SWDATA = 2'd1;
  localparam logic [1:0] ADDR_PRESC  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [1:0] MODE_SW     = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t             state, state_d;

  logic               ctrl_en;
  logic [1:0]         ctrl_mode;
  logic               ctrl_dip_sel;
  logic [LED_W-1:0]   swdata;
  logic [PRESC_W-1:0] presc;

  logic [PRESC_W-1:0] cnt, cnt_d, presc_last;
  logic [LED_W-1:0]   led_q, led_d, seed, step_led;
  logic               dir, dir_d, step_dir;
  logic               evt, evt_set;
  logic               tick, do_step;

  logic [3:0]         btn_s1, btn_s2, btn_prev, btn_sync, btn_press;
  logic [3:0]         dip_s1, dip_s2;
  logic [1:0]         eff_mode, eff_mode_q;
  logic               mode_chg;

  logic               wr_ctrl, wr_swdata, wr_presc, wr_status;
  logic [31:0]        rd_mux;

  logic               unused_bits;
  assign unused_bits = &{1'b0, avs_writedata, dip_s2[3:2]};

  assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
  assign wr_swdata = avs_write && (avs_address == ADDR_SWDATA);
  assign wr_presc  = avs_write && (avs_address == ADDR_PRESC);
  assign wr_status = avs_write && (avs_address == ADDR_STATUS);

  // Buttons and switches come straight off the board pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1   <= 4'hF;
      btn_s2   <= 4'hF;
      btn_prev <= 4'h0;
      dip_s1   <= 4'h0;
      dip_s2   <= 4'h0;
    end else begin
      btn_s1   <= buttons_n;
      btn_s2   <= btn_s1;
      btn_prev <= btn_sync;
      dip_s1   <= dipsw;
      dip_s2   <= dip_s1;
    end
  end

  assign btn_sync  = ~btn_s2;
  assign btn_press = btn_sync & ~btn_prev;

  assign eff_mode = ctrl_dip_sel ? dip_s2[1:0] : ctrl_mode;
  assign mode_chg = (eff_mode != eff_mode_q);

  // Period P = max(PRESC,1): a zero period behaves like one step per clock.
  assign presc_last = (presc == '0) ? '0 : presc - PRESC_W'(1);
  assign tick       = (state == ST_RUN) && (cnt == presc_last);
  assign do_step    = tick || ((state == ST_PAUSE) && btn_press[1] && !btn_press[0]);

  // Rotate/bounce need a lit bit to move, so a blank seed becomes bit 0.
  always_comb begin
    seed = swdata;
    if ((swdata == '0) && ((eff_mode == MODE_ROTATE) || (eff_mode == MODE_BOUNCE)))
      seed = LED_W'(1);
  end

  always_comb begin
    step_led = led_q;
    step_dir = dir;
    case (eff_mode)
      MODE_ROTATE: step_led = {led_q[LED_W-2:0], led_q[LED_W-1]};
      MODE_BOUNCE: begin
        if (led_q == '0) begin
          step_led = LED_W'(1);
          step_dir = 1'b0;
        end else if (!dir) begin
          step_led = led_q << 1;
          if (step_led[LED_W-1]) step_dir = 1'b1;
        end else begin
          step_led = led_q >> 1;
          if (step_led[0]) step_dir = 1'b0;
        end
      end
      MODE_BLINK:  step_led = (led_q == '0) ? swdata : '0;
      default:     step_led = led_q;
    endcase
  end

  always_comb begin
    state_d = state;
    if (!ctrl_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   if (btn_press[0]) state_d = ST_PAUSE;
        ST_PAUSE: if (btn_press[0]) state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    led_d   = led_q;
    dir_d   = dir;
    cnt_d   = cnt;
    evt_set = 1'b0;
    if (state == ST_IDLE) begin
      led_d = ctrl_en ? seed : '0;
      dir_d = 1'b0;
      cnt_d = '0;
    end else if (!ctrl_en) begin
      led_d = '0;
      dir_d = 1'b0;
      cnt_d = '0;
    end else begin
      if (state == ST_RUN)
        cnt_d = tick ? '0 : cnt + PRESC_W'(1);
      // Reseeding on a mode change overrides any step due in the same cycle.
      if (mode_chg) begin
        led_d = seed;
        dir_d = 1'b0;
        cnt_d = '0;
      end else if (eff_mode == MODE_SW) begin
        led_d = swdata;
      end else if (do_step) begin
        led_d   = step_led;
        dir_d   = step_dir;
        evt_set = 1'b1;
      end
      if (wr_presc) cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q      <= '0;
      dir        <= 1'b0;
      cnt        <= '0;
      evt        <= 1'b0;
      eff_mode_q <= MODE_SW;
    end else begin
      led_q      <= led_d;
      dir        <= dir_d;
      cnt        <= cnt_d;
      eff_mode_q <= eff_mode;
      // A step in the same cycle as a write-1-clear keeps the flag set.
      if (evt_set)                          evt <= 1'b1;
      else if (wr_status && avs_writedata[16]) evt <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en      <= 1'b0;
      ctrl_mode    <= MODE_SW;
      ctrl_dip_sel <= 1'b0;
      swdata       <= '0;
      presc        <= PRESC_W'(PRESC_RST);
    end else begin
      if (wr_ctrl) begin
        ctrl_en      <= avs_writedata[0];
        ctrl_mode    <= avs_writedata[2:1];
        ctrl_dip_sel <= avs_writedata[3];
      end
      if (wr_swdata) swdata <= avs_writedata[LED_W-1:0];
      if (wr_presc)  presc  <= avs_writedata[PRESC_W-1:0];
    end
  end

  // STATUS packs leds into the low byte; LED_W is expected to be at most 8.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_CTRL:   rd_mux[3:0] = {ctrl_dip_sel, ctrl_mode, ctrl_en};
      ADDR_SWDATA: rd_mux[LED_W-1:0] = swdata;
      ADDR_PRESC:  rd_mux[PRESC_W-1:0] = presc;
      default: begin
        rd_mux[LED_W-1:0] = led_q;
        rd_mux[8]         = dir;
        rd_mux[12:9]      = btn_sync;
        rd_mux[14:13]     = state;
        rd_mux[16]        = evt;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
  end

  assign leds = led_q;

endmodule

// File: tb/tb_avalon_led_sequencer.sv
// Directed bench for avalon_led_sequencer: driver tasks queue expected read data and LED
// values; a negedge monitor pops and compares them as the DUT presents each output.
module tb_avalon_led_sequencer;

  localparam int LED_W     = 8;
  localparam int PRESC_W   = 24;
  localparam int PRESC_RST = 5_000_000;

  logic             clk;
  logic             reset;
  logic [1:0]       avs_address;
  logic             avs_read;
  logic             avs_write;
  logic [31:0]      avs_writedata;
  logic [31:0]      avs_readdata;
  logic [3:0]       buttons_n;
  logic [3:0]       dipsw;
  logic [LED_W-1:0] leds;

  avalon_led_sequencer #(
    .LED_W(LED_W), .PRESC_W(PRESC_W), .PRESC_RST(PRESC_RST)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .buttons_n(buttons_n), .dipsw(dipsw), .leds(leds)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 ns");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;

  logic [31:0]      exp_q[$];
  logic [31:0]      msk_q[$];
  string            tag_q[$];
  logic [LED_W-1:0] led_exp_q[$];
  string            led_tag_q[$];
  logic             led_chk;
  logic             rd_vld;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, act, exp);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) rd_vld <= 1'b0;
    else       rd_vld <= avs_read;
  end

  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        check("read_underflow", 32'd1, 32'd0);
      end else begin
        logic [31:0] e, m;
        string t;
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        t = tag_q.pop_front();
        check(t, avs_readdata & m, e);
      end
    end
    if (led_chk) begin
      if (led_exp_q.size() == 0) begin
        check("led_underflow", 32'd1, 32'd0);
      end else begin
        logic [LED_W-1:0] le;
        string lt;
        le = led_exp_q.pop_front();
        lt = led_tag_q.pop_front();
        check(lt, 32'(leds), 32'(le));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycs(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    cyc();
    avs_write     = 1'b0;
  endtask

  task automatic rd_issue(input logic [1:0] a, input logic [31:0] e, input logic [31:0] m,
                          input string tag);
    avs_address = a;
    avs_read    = 1'b1;
    exp_q.push_back(e & m);
    msk_q.push_back(m);
    tag_q.push_back(tag);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input logic [31:0] m,
                    input string tag);
    rd_issue(a, e, m, tag);
    cyc();
    avs_read = 1'b0;
  endtask

  // Checks the LED value visible during the current cycle, then advances one clock.
  task automatic led_cyc(input logic [LED_W-1:0] e, input string tag);
    led_exp_q.push_back(e);
    led_tag_q.push_back(tag);
    led_chk = 1'b1;
    cyc();
    led_chk  = 1'b0;
    avs_read = 1'b0;
  endtask

  task automatic press(input int b, input logic [31:0] st_exp, input string tag);
    buttons_n[b] = 1'b0;
    cycs(3);
    rd(2'd3, st_exp, 32'h0000_7E00, tag);
    buttons_n[b] = 1'b1;
    cycs(3);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] rot_tab[9]    = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] bounce_tab[16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] blink_tab[8]  = '{8'hA5, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'h00, 8'h00};
  logic [7:0] mchg_tab[8]   = '{8'h3C, 8'h3C, 8'h3C, 8'h78, 8'h78, 8'hF0, 8'hF0, 8'hE1};

  initial begin
    reset = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; buttons_n = 4'hF; dipsw = 4'h0; led_chk = 1'b0;
    cycs(3);
    reset = 1'b0;
    cyc();

    // reset state
    check("reset_readdata", avs_readdata, 32'h0);
    rd(2'd0, 32'h0, 32'hFFFF_FFFF, "reset_ctrl");
    rd(2'd1, 32'h0, 32'hFFFF_FFFF, "reset_swdata");
    rd(2'd2, 32'(PRESC_RST), 32'hFFFF_FFFF, "reset_presc");
    rd(2'd3, 32'h0, 32'hFFFF_FFFF, "reset_status");
    led_cyc(8'h00, "reset_leds");

    // ROTATE, PRESC=4: each pattern holds for 4 clocks
    wr(2'd2, 32'd4);
    wr(2'd1, 32'h0);
    wr(2'd0, 32'h03);
    led_cyc(8'h00, "rot_idle");
    for (int p = 0; p < 9; p++)
      for (int j = 0; j < 4; j++) led_cyc(rot_tab[p], $sformatf("rot_%0d_%0d", p, j));
    rd(2'd3, 32'h0001_2000, 32'h0001_6000, "rot_evt_run");
    wr(2'd0, 32'h0);
    cyc();
    led_cyc(8'h00, "rot_disable_leds");
    rd(2'd3, 32'h0001_0000, 32'h0001_6000, "idle_evt_sticky");
    wr(2'd3, 32'h0001_0000);
    rd(2'd3, 32'h0, 32'hFFFF_FFFF, "evt_w1c");

    // BOUNCE, PRESC=0: one step per clock, dir flips at both ends
    wr(2'd2, 32'd0);
    wr(2'd0, 32'h05);
    led_cyc(8'h00, "bnc_idle");
    for (int i = 0; i < 16; i++) begin
      logic [31:0] st;
      st = 32'h0000_2000 | 32'(bounce_tab[i]) | ((i >= 7 && i <= 13) ? 32'h100 : 32'h0);
      rd_issue(2'd3, st, 32'h0000_61FF, $sformatf("bnc_status_%0d", i));
      led_cyc(bounce_tab[i], $sformatf("bnc_led_%0d", i));
    end
    wr(2'd0, 32'h0);
    cyc();

    // pause / single step / resume
    wr(2'd2, 32'd1000);
    wr(2'd1, 32'h81);
    wr(2'd0, 32'h03);
    cyc();
    led_cyc(8'h81, "pause_seed");
    press(0, 32'h0000_4200, "pause_enter");
    wr(2'd2, 32'd2);
    cycs(10);
    led_cyc(8'h81, "pause_frozen");
    wr(2'd3, 32'h0001_0000);
    rd(2'd3, 32'h0, 32'h0001_0000, "pause_evt_clear");
    press(1, 32'h0000_4400, "pause_btn1");
    led_cyc(8'h03, "pause_one_step");
    rd(2'd3, 32'h0001_4003, 32'h0001_7FFF, "pause_step_status");
    cycs(8);
    led_cyc(8'h03, "pause_still_frozen");
    press(0, 32'h0000_2200, "resume_run");
    wr(2'd0, 32'h0);
    cyc();

    // BLINK selected by DIP switches
    dipsw = 4'b0011;
    wr(2'd1, 32'hA5);
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h09);
    led_cyc(8'h00, "blink_idle");
    for (int i = 0; i < 8; i++) led_cyc(blink_tab[i], $sformatf("blink_%0d", i));
    rd(2'd0, 32'h9, 32'hFFFF_FFFF, "blink_ctrl");
    wr(2'd0, 32'h0);
    cyc();
    dipsw = 4'b0000;

    // SW mode follows SWDATA one clock after the write
    wr(2'd0, 32'h01);
    led_cyc(8'h00, "sw_idle");
    led_cyc(8'hA5, "sw_initial");
    wr(2'd1, 32'h3C);
    led_cyc(8'hA5, "sw_write_delay");
    led_cyc(8'h3C, "sw_follow");
    rd(2'd3, 32'h3C, 32'h0000_00FF, "sw_status_leds");
    rd(2'd1, 32'h3C, 32'hFFFF_FFFF, "sw_swdata");

    // mode change while running reseeds from SWDATA, then rotates with PRESC=2
    wr(2'd0, 32'h03);
    for (int i = 0; i < 8; i++) led_cyc(mchg_tab[i], $sformatf("mchg_%0d", i));

    // reset mid-RUN with leds=0x10
    wr(2'd0, 32'h01);
    wr(2'd1, 32'h10);
    cycs(2);
    led_cyc(8'h10, "pre_reset_leds");
    rd(2'd1, 32'h10, 32'hFFFF_FFFF, "pre_reset_swdata");
    cyc();
    reset = 1'b1;
    #1;
    check("async_reset_leds", 32'(leds), 32'h0);
    check("async_reset_readdata", avs_readdata, 32'h0);
    cycs(2);
    reset = 1'b0;
    cyc();
    rd(2'd2, 32'(PRESC_RST), 32'hFFFF_FFFF, "post_reset_presc");
    rd(2'd3, 32'h0, 32'hFFFF_FFFF, "post_reset_status");
    led_cyc(8'h00, "post_reset_leds");

    // unused register bits read zero
    wr(2'd0, 32'hFFFF_FFF8);
    rd(2'd0, 32'h8, 32'hFFFF_FFFF, "ctrl_unused_bits");
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, 32'h00FF_FFFF, 32'hFFFF_FFFF, "presc_unused_bits");
    wr(2'd1, 32'hFFFF_FF5A);
    rd(2'd1, 32'h5A, 32'hFFFF_FFFF, "swdata_unused_bits");

    cycs(3);
    check("scoreboard_drained", 32'(exp_q.size() + led_exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
